// File: rtl/uart_tx_frame_if.sv
// Request/data handshake and serial-line outputs of the 8N1 frame transmitter.
interface uart_tx_frame_if;
  logic       transmit;
  logic [7:0] data_in;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (output transmit, output data_in, input tx, input busy, input done);
  modport slave  (input transmit, input data_in, output tx, output busy, output done);
endinterface

// File: rtl/uart_tx_frame.sv
// 8N1 UART frame serialiser: one frame per low->high edge of the debounced
// transmit level, data word latched at frame start.
//
// state | meaning
// IDLE  | line high, waiting for a transmit rising edge
// START | start bit (line low)
// DATA  | eight data bits, LSB first
// STOP  | stop bit (line high); done pulses on exit
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_frame_if.slave  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shreg_q;
  logic          transmit_q;
  logic          tx_q;
  logic          busy_q;
  logic          done_q;
  logic          baud_end_d;
  logic          start_d;

  assign baud_end_d = (baud_q == BAUD_LAST);
  assign start_d    = bus.transmit & ~transmit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      // Reset to 1 so a request held through reset release is not an edge.
      transmit_q <= 1'b1;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      transmit_q <= bus.transmit;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_d) begin
            state_q   <= START;
            shreg_q   <= bus.data_in;
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          if (baud_end_d) begin
            state_q <= DATA;
            baud_q  <= '0;
            tx_q    <= shreg_q[0];
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        DATA: begin
          if (baud_end_d) begin
            baud_q  <= '0;
            shreg_q <= {1'b0, shreg_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shreg_q[1];
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        STOP: begin
          if (baud_end_d) begin
            state_q <= IDLE;
            baud_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
